// File: rtl/ram_ctrl.sv
// MEM-stage SRAM responder: turns one load/store request into a timed
// SETUP/ACCESS/DONE cycle on asynchronous SRAM, stalling the pipeline meanwhile.
module ram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  input  logic [31:0]       sram_din,
  output logic              sram_drive,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                wr_q, wr_nx, rd_q, rd_nx, byte_q, byte_nx;
  logic [1:0]          off_q, off_nx;
  logic [31:0]         rdata_nx, dout_nx;
  logic                valid_nx, drive_nx, ce_n_nx, oe_n_nx, we_n_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [3:0]          be_n_nx;

  // Only the word-address bits reach the SRAM; the rest of the byte address is ignored.
  generate
    if (ADDR_W + 2 < 32) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    end
  endgenerate

  assign stall = ((state == IDLE) && (req_read || req_write)) ||
                 (state == SETUP) || (state == ACCESS);

  // Outputs are registered, so each branch computes the pin values for the
  // state being entered rather than the state being left.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path leaves one unassigned and no latch is inferred.
    state_nx = state;
    cnt_nx   = cnt;
    wr_nx    = wr_q;
    rd_nx    = rd_q;
    byte_nx  = byte_q;
    off_nx   = off_q;
    rdata_nx = rdata;
    valid_nx = rdata_valid;
    addr_nx  = sram_addr;
    dout_nx  = sram_dout;
    be_n_nx  = sram_be_n;
    drive_nx = sram_drive;
    ce_n_nx  = sram_ce_n;
    oe_n_nx  = sram_oe_n;
    we_n_nx  = sram_we_n;

    case (state)
      IDLE: begin
        ce_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        drive_nx = 1'b0;
        valid_nx = 1'b0;
        if (req_read || req_write) begin
          state_nx = SETUP;
          wr_nx    = req_write;
          rd_nx    = req_read && !req_write;
          byte_nx  = req_byte;
          off_nx   = req_addr[1:0];
          addr_nx  = req_addr[ADDR_W+1:2];
          if (req_byte) begin
            be_n_nx = ~(4'b0001 << req_addr[1:0]);
            dout_nx = {4{req_wdata[7:0]}};
          end else begin
            be_n_nx = 4'h0;
            dout_nx = req_wdata;
          end
          ce_n_nx = 1'b0;
          if (req_write) drive_nx = 1'b1;
          else           oe_n_nx  = 1'b0;
        end
      end
      SETUP: begin
        state_nx = ACCESS;
        cnt_nx   = CNT_LOAD;
        if (wr_q) we_n_nx = 1'b0;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
          we_n_nx  = 1'b1;
          valid_nx = rd_q;
          if (rd_q)
            rdata_nx = byte_q ? {24'b0, sram_din[{off_q, 3'b000} +: 8]} : sram_din;
          else
            rdata_nx = 32'h0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        // Requests seen here belong to the instruction leaving MEM; never re-accept.
        state_nx = IDLE;
        ce_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        drive_nx = 1'b0;
        valid_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      byte_q      <= 1'b0;
      off_q       <= 2'd0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      sram_addr   <= '0;
      sram_dout   <= 32'h0;
      sram_be_n   <= 4'hF;
      sram_drive  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      wr_q        <= wr_nx;
      rd_q        <= rd_nx;
      byte_q      <= byte_nx;
      off_q       <= off_nx;
      rdata       <= rdata_nx;
      rdata_valid <= valid_nx;
      sram_addr   <= addr_nx;
      sram_dout   <= dout_nx;
      sram_be_n   <= be_n_nx;
      sram_drive  <= drive_nx;
      sram_ce_n   <= ce_n_nx;
      sram_oe_n   <= oe_n_nx;
      sram_we_n   <= we_n_nx;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with WAIT_CYCLES=2: per-cycle pin timing for
// reads, writes, byte lanes, reset abort and back-to-back requests.
module tb_ram_ctrl;

  localparam int ADDR_W = 20;
  localparam int NCYC   = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_read, req_write, req_byte;
  logic [31:0]       req_addr, req_wdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dout, sram_din;
  logic              sram_drive, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]        sram_be_n;

  int checks = 0;
  int errors = 0;

  // Per-cycle samples of one access, cycle 0 = request cycle.
  logic              s_stall [NCYC];
  logic              s_valid [NCYC];
  logic              s_drive [NCYC];
  logic              s_ce_n  [NCYC];
  logic              s_oe_n  [NCYC];
  logic              s_we_n  [NCYC];
  logic [3:0]        s_be_n  [NCYC];
  logic [31:0]       s_rdata [NCYC];
  logic [31:0]       s_dout  [NCYC];
  logic [ADDR_W-1:0] s_addr  [NCYC];

  ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  // Drives a request starting at cycle 0, drops it at cycle `hold`, samples at each negedge.
  task automatic run_access(input logic rd, input logic wr, input logic bt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int hold, input int ncyc);
    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_byte = bt; req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      s_stall[c] = stall;     s_valid[c] = rdata_valid; s_drive[c] = sram_drive;
      s_ce_n[c]  = sram_ce_n; s_oe_n[c]  = sram_oe_n;   s_we_n[c]  = sram_we_n;
      s_be_n[c]  = sram_be_n; s_rdata[c] = rdata;       s_dout[c]  = sram_dout;
      s_addr[c]  = sram_addr;
      @(posedge clk); #1;
      if (c + 1 == hold) begin
        req_read = 1'b0; req_write = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 req_read = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive, rdata_valid} !== 5'b11100) begin
      errors++; $display("FAIL reset_ctrl got %b expected 11100", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive, rdata_valid});
    end
    checks++;
    if ({sram_be_n, sram_addr, sram_dout, rdata} !== {4'hF, 20'h0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL reset_data be_n %h addr %h dout %h rdata %h", sram_be_n, sram_addr, sram_dout, rdata);
    end
    @(posedge clk); #1;
    req_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b expected 0", stall);
    end
  endtask

  task automatic test_word_read();
    sram_din = 32'hDEADBEEF;
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 5, 6);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (s_stall[c] !== (c <= 3)) begin
        errors++; $display("FAIL word_read_stall cycle %0d got %b expected %b", c, s_stall[c], c <= 3);
      end
    end
    checks++;
    if (s_addr[1] !== 20'h41 || s_addr[4] !== 20'h41) begin
      errors++; $display("FAIL word_read_addr got %h/%h expected 41", s_addr[1], s_addr[4]);
    end
    checks++;
    if ({s_ce_n[1], s_oe_n[1], s_drive[1], s_we_n[1]} !== 4'b0001) begin
      errors++; $display("FAIL word_read_setup ce/oe/drive/we got %b expected 0001", {s_ce_n[1], s_oe_n[1], s_drive[1], s_we_n[1]});
    end
    checks++;
    if (s_rdata[4] !== 32'hDEADBEEF || s_valid[4] !== 1'b1 || s_valid[3] !== 1'b0) begin
      errors++; $display("FAIL word_read_data got %h valid %b/%b expected DEADBEEF valid 0/1", s_rdata[4], s_valid[3], s_valid[4]);
    end
    checks++;
    if (s_ce_n[4] !== 1'b0 || s_ce_n[5] !== 1'b1 || s_oe_n[5] !== 1'b1 || s_valid[5] !== 1'b0 || s_rdata[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_read_after ce_n %b/%b oe_n %b valid %b rdata %h", s_ce_n[4], s_ce_n[5], s_oe_n[5], s_valid[5], s_rdata[5]);
    end
  endtask

  task automatic test_byte_read();
    sram_din = 32'h11223344;
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0106, 32'h0, 5, 6);
    checks++;
    if (s_rdata[4] !== 32'h0000_0022 || s_valid[4] !== 1'b1) begin
      errors++; $display("FAIL byte_read_data got %h valid %b expected 00000022 valid 1", s_rdata[4], s_valid[4]);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (s_be_n[c] !== 4'b1011) begin
        errors++; $display("FAIL byte_read_be_n cycle %0d got %b expected 1011", c, s_be_n[c]);
      end
    end
  endtask

  task automatic test_byte_write();
    run_access(1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_00A5, 5, 6);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (s_we_n[c] !== !(c == 2 || c == 3) || s_drive[c] !== (c >= 1 && c <= 4)) begin
        errors++; $display("FAIL byte_write_we_drive cycle %0d got we_n %b drive %b", c, s_we_n[c], s_drive[c]);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (s_dout[c] !== 32'hA5A5A5A5 || s_be_n[c] !== 4'b0111 || s_oe_n[c] !== 1'b1) begin
        errors++; $display("FAIL byte_write_bus cycle %0d dout %h be_n %b oe_n %b expected A5A5A5A5 0111 1", c, s_dout[c], s_be_n[c], s_oe_n[c]);
      end
    end
    checks++;
    if (s_valid[4] !== 1'b0) begin
      errors++; $display("FAIL byte_write_valid got %b expected 0", s_valid[4]);
    end
  endtask

  task automatic test_read_write_both();
    sram_din = 32'hFFFFFFFF;
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h12345678, 5, 6);
    checks++;
    if (s_addr[1] !== 20'h2 || s_dout[1] !== 32'h12345678 || s_be_n[1] !== 4'h0) begin
      errors++; $display("FAIL both_bus addr %h dout %h be_n %b expected 2 12345678 0000", s_addr[1], s_dout[1], s_be_n[1]);
    end
    checks++;
    if ({s_we_n[2], s_we_n[3], s_drive[2], s_oe_n[1]} !== 4'b0011) begin
      errors++; $display("FAIL both_write we_n %b%b drive %b oe_n %b expected write cycle", s_we_n[2], s_we_n[3], s_drive[2], s_oe_n[1]);
    end
    checks++;
    if (s_valid[4] !== 1'b0 || s_rdata[4] !== 32'h0) begin
      errors++; $display("FAIL both_rdata valid %b rdata %h expected 0 00000000", s_valid[4], s_rdata[4]);
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'hFFFF0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pre we_n got %b expected 0", sram_we_n);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_we_n, sram_ce_n, sram_oe_n, sram_drive, stall, sram_be_n} !== {5'b11100, 4'hF}) begin
      errors++; $display("FAIL reset_mid_abort we/ce/oe/drive/stall/be_n got %b expected 111001111", {sram_we_n, sram_ce_n, sram_oe_n, sram_drive, stall, sram_be_n});
    end
    sram_din = 32'hCAFEF00D;
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5, 6);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (s_stall[c] !== (c <= 3)) begin
        errors++; $display("FAIL reset_mid_rerun_stall cycle %0d got %b expected %b", c, s_stall[c], c <= 3);
      end
    end
    checks++;
    if (s_rdata[4] !== 32'hCAFEF00D || s_valid[4] !== 1'b1 || s_addr[4] !== 20'h4) begin
      errors++; $display("FAIL reset_mid_rerun_data got %h valid %b addr %h expected CAFEF00D 1 4", s_rdata[4], s_valid[4], s_addr[4]);
    end
  endtask

  task automatic test_back_to_back();
    sram_din = 32'h55AA55AA;
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 10, 11);
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (s_stall[c] !== (c <= 3 || (c >= 5 && c <= 8))) begin
        errors++; $display("FAIL b2b_stall cycle %0d got %b", c, s_stall[c]);
      end
      checks++;
      if (s_valid[c] !== (c == 4 || c == 9)) begin
        errors++; $display("FAIL b2b_valid cycle %0d got %b", c, s_valid[c]);
      end
    end
    checks++;
    if (s_ce_n[5] !== 1'b1 || s_ce_n[6] !== 1'b0 || s_rdata[9] !== 32'h55AA55AA) begin
      errors++; $display("FAIL b2b_gap ce_n %b/%b rdata %h expected 1/0 55AA55AA", s_ce_n[5], s_ce_n[6], s_rdata[9]);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; sram_din = 32'h0;
    test_reset();
    test_word_read();
    test_byte_read();
    test_byte_write();
    test_read_write_both();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Memory-side responder for the MEM pipeline stage: accepts a load/store request, runs a multi-cycle access on external asynchronous SRAM, and stalls the pipeline until the access finishes.
- Returns load data with the addressed byte placed in bits [7:0] on byte loads, which is the lane the MEM stage sign-extends.
- Sits between the MEM stage and the board SRAM pins; the pipeline control unit consumes its stall output.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 2, SRAM access cycles held in ACCESS; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- req_read  in  1  load request from the MEM stage.
- req_write  in  1  store request from the MEM stage.
- req_byte  in  1  1 = byte access (LB/SB), 0 = word access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte stores use bits [7:0].
- stall  out  1  freeze the pipeline.
- rdata  out  32  load data to the MEM stage (its RAMData input).
- rdata_valid  out  1  rdata is valid this cycle.
- sram_addr  out  ADDR_W  word address.
- sram_dout  out  32  data driven to SRAM.
- sram_din  in  32  data from SRAM.
- sram_drive  out  1  1 = tristate driver enabled (sram_dout on bus).
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_be_n  out  4  byte enables, active-low.

Behaviour:
- States: IDLE, SETUP, ACCESS, DONE. All outputs except stall are registered.
- Reset (reset=0 at a clock edge) forces:
  - state = IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_be_n = 4'hF.
  - sram_drive = 0; sram_addr = 0; sram_dout = 0.
  - rdata = 0; rdata_valid = 0.
  - stall = 0 from the following cycle.
- Reset mid-access aborts the access immediately with the values above. No pending state survives reset.
- stall = (IDLE and (req_read or req_write)) or SETUP or ACCESS. stall is combinational from state and requests, and is 0 in DONE.
- IDLE:
  - If req_write or req_read is high: latch the request, go to SETUP.
  - If req_read and req_write are both high: treat as a write. rdata = 0 in DONE, rdata_valid = 0.
- Request latching:
  - sram_addr = req_addr[ADDR_W+1:2]; req_addr[1:0] is ignored for word accesses.
  - Byte access: sram_be_n = ~(4'b0001 << req_addr[1:0]); sram_dout = {4{req_wdata[7:0]}}.
  - Word access: sram_be_n = 4'h0; sram_dout = req_wdata.
- SETUP (1 cycle):
  - sram_ce_n = 0.
  - Write: sram_drive = 1, sram_we_n = 1.
  - Read: sram_oe_n = 0, sram_drive = 0.
  - Then go to ACCESS and load the wait counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Write: sram_we_n = 0.
  - Decrement the counter each cycle.
  - On the last ACCESS cycle, a read captures sram_din.
  - Go to DONE.
- DONE (1 cycle):
  - sram_we_n = 1; sram_ce_n and sram_drive stay asserted this cycle for hold time.
  - Read: rdata_valid = 1. Byte read gives rdata = {24'b0, captured byte selected by addr[1:0]}, lane 0 = bits [7:0]. Word read gives rdata = captured word.
  - Go to IDLE unconditionally. Requests present during DONE are not re-accepted, because they belong to the instruction now leaving MEM.
- IDLE after DONE:
  - sram_ce_n = 1, sram_oe_n = 1, sram_drive = 0, rdata_valid = 0.
  - rdata holds its last value.
- Latency for a request at cycle 0: stall is high in cycles 0..WAIT_CYCLES+1, and DONE is cycle WAIT_CYCLES+2. Back-to-back requests therefore leave one IDLE cycle between accesses.
- sram_addr, sram_be_n and sram_dout are stable from SETUP through DONE.

Test Plan:
- Word read, WAIT_CYCLES=2:
  - Stimulus: addr 0x00000104, SRAM word 0xDEADBEEF.
  - Required: sram_addr = 0x41; stall high in cycles 0-3; cycle 4 gives rdata = 0xDEADBEEF with rdata_valid = 1 and stall = 0.
- Byte read:
  - Stimulus: addr 0x00000106, SRAM word 0x11223344.
  - Required: rdata = 0x00000022; sram_be_n = 4'b1011 during SETUP..DONE.
- Byte write:
  - Stimulus: addr 0x00000003, wdata 0x000000A5.
  - Required: sram_dout = 0xA5A5A5A5; be_n = 4'b0111; we_n low in exactly cycles 2-3; drive high in cycles 1-4.
- Simultaneous read and write:
  - Stimulus: req_read = req_write = 1, addr 0x8, wdata 0x12345678.
  - Required: a write occurs; rdata_valid stays 0.
- Reset mid-access:
  - Stimulus: reset = 0 during ACCESS.
  - Required: next cycle we_n = ce_n = oe_n = 1, be_n = F, drive = 0, state IDLE, stall = 0 with no request; the next request runs the full sequence again.
- Back-to-back reads held through DONE:
  - Stimulus: a request in DONE is not re-accepted; a new request in the following IDLE cycle starts SETUP one cycle later.
  - Required: total of 10 cycles for two reads with WAIT_CYCLES=2.
